// File: rtl/branch_target_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// Lookup is combinational: the IF stage gets a prediction for the fetch PC in
// the same cycle. The ID stage trains the table through a single write port.
// Optional statistics counters are enabled by the macro BRANCH_TARGET_PREDICTOR_STATS_EN.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            lookup_valid_i,
    input  logic [PC_W-1:0] lookup_pc_i,
    output logic            pred_hit_o,
    output logic            pred_taken_o,
    output logic [PC_W-1:0] pred_next_pc_o,
    input  logic            update_valid_i,
    input  logic [PC_W-1:0] update_pc_i,
    input  logic            update_taken_i,
    input  logic [PC_W-1:0] update_target_i,
`ifdef BRANCH_TARGET_PREDICTOR_STATS_EN
    input  logic            invalidate_i,
    output logic [31:0]     stat_lookups_o,
    output logic [31:0]     stat_mispredicts_o
`else
    input  logic            invalidate_i
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    // Counter encodings: weakly taken is MSB set with the rest clear, weakly
    // not taken is one below it.
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [PC_W-1:0]    target_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [CNT_W-1:0]   cnt_d    [ENTRIES];

    logic [IDX_W-1:0] l_idx_s, u_idx_s;
    logic [TAG_W-1:0] l_tag_s, u_tag_s;
    logic             u_hit_s;

    assign l_idx_s = lookup_pc_i[IDX_W+1:2];
    assign l_tag_s = lookup_pc_i[PC_W-1:IDX_W+2];
    assign u_idx_s = update_pc_i[IDX_W+1:2];
    assign u_tag_s = update_pc_i[PC_W-1:IDX_W+2];
    assign u_hit_s = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);

    // Zero-latency prediction from the current table contents (no update bypass).
    always_comb begin
        pred_hit_o     = 1'b0;
        pred_taken_o   = 1'b0;
        pred_next_pc_o = lookup_pc_i + PC_W'(4);
        if (valid_q[l_idx_s] && (tag_q[l_idx_s] == l_tag_s)) begin
            pred_hit_o   = 1'b1;
            pred_taken_o = cnt_q[l_idx_s][CNT_W-1];
            if (cnt_q[l_idx_s][CNT_W-1]) begin
                pred_next_pc_o = target_q[l_idx_s];
            end else begin
                pred_next_pc_o = lookup_pc_i + PC_W'(4);
            end
        end else begin
            pred_hit_o = 1'b0;
        end
    end

    // Next table state: invalidate beats training; training touches one entry.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (invalidate_i) begin
            valid_d = '0;
        end else if (update_valid_i) begin
            if (u_hit_s) begin
                if (update_taken_i) begin
                    target_d[u_idx_s] = update_target_i;
                    if (cnt_q[u_idx_s] != CNT_MAX) begin
                        cnt_d[u_idx_s] = cnt_q[u_idx_s] + CNT_W'(1);
                    end else begin
                        cnt_d[u_idx_s] = cnt_q[u_idx_s];
                    end
                end else begin
                    if (cnt_q[u_idx_s] != CNT_W'(0)) begin
                        cnt_d[u_idx_s] = cnt_q[u_idx_s] - CNT_W'(1);
                    end else begin
                        cnt_d[u_idx_s] = cnt_q[u_idx_s];
                    end
                end
            end else if (update_taken_i) begin
                // Allocate, replacing whatever aliasing entry held this slot.
                valid_d[u_idx_s]  = 1'b1;
                tag_d[u_idx_s]    = u_tag_s;
                target_d[u_idx_s] = update_target_i;
                cnt_d[u_idx_s]    = CNT_WT;
            end else begin
                valid_d = valid_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Table storage, cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef BRANCH_TARGET_PREDICTOR_STATS_EN
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;
    logic        u_pred_taken_s;
    logic        u_wrong_s;

    // Prediction the table would have given for the resolved PC before training.
    assign u_pred_taken_s = u_hit_s && cnt_q[u_idx_s][CNT_W-1];
    assign u_wrong_s      = (u_pred_taken_s != update_taken_i) ||
                            (u_pred_taken_s && update_taken_i &&
                             (target_q[u_idx_s] != update_target_i));

    // Wrapping statistics; invalidate does not clear them.
    always_comb begin
        stat_lookups_d     = stat_lookups_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (lookup_valid_i) begin
            stat_lookups_d = stat_lookups_q + 32'd1;
        end else begin
            stat_lookups_d = stat_lookups_q;
        end
        if (update_valid_i && !invalidate_i && u_wrong_s) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end else begin
            stat_mispredicts_d = stat_mispredicts_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_lookups_q     <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups_o     = stat_lookups_q;
    assign stat_mispredicts_o = stat_mispredicts_q;

    logic unused_s;
    assign unused_s = ^{lookup_pc_i[1:0], update_pc_i[1:0]};
`else
    logic unused_s;
    assign unused_s = ^{lookup_valid_i, lookup_pc_i[1:0], update_pc_i[1:0]};
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed plus randomized bench for branch_target_predictor (16 entries,
// 32-bit PC, 2-bit counters) against an array-based reference model.
module tb_branch_target_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lookup_valid_i = 1'b0;
    logic [31:0] lookup_pc_i = 32'd0;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_next_pc_o;
    logic        update_valid_i = 1'b0;
    logic [31:0] update_pc_i = 32'd0;
    logic        update_taken_i = 1'b0;
    logic [31:0] update_target_i = 32'd0;
    logic        invalidate_i = 1'b0;
`ifdef BRANCH_TARGET_PREDICTOR_STATS_EN
    logic [31:0] stat_lookups_o;
    logic [31:0] stat_mispredicts_o;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: one record per slot, counter kept as a plain integer 0..3.
    logic        m_valid  [16];
    logic [31:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_cnt    [16];
    int          m_lookups;
    int          m_mispred;

    branch_target_predictor #(.ENTRIES(16), .PC_W(32), .CNT_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
        .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o),
        .pred_next_pc_o(pred_next_pc_o),
        .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
        .update_taken_i(update_taken_i), .update_target_i(update_target_i),
`ifdef BRANCH_TARGET_PREDICTOR_STATS_EN
        .invalidate_i(invalidate_i),
        .stat_lookups_o(stat_lookups_o),
        .stat_mispredicts_o(stat_mispredicts_o)
`else
        .invalidate_i(invalidate_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / 32'd64;
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic logic m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 32'd0;
            m_target[i] = 32'd0;
            m_cnt[i]    = 1;
        end
        m_lookups = 0;
        m_mispred = 0;
    endtask

    // Apply one clock edge of the specified training rules to the model.
    task automatic model_clock();
        int  ix;
        logic pt;
        ix = idx_of(update_pc_i);
        pt = m_taken(update_pc_i);
        if (lookup_valid_i) m_lookups++;
        if (invalidate_i) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (update_valid_i) begin
            if ((pt != update_taken_i) ||
                (pt && update_taken_i && m_target[ix] != update_target_i))
                m_mispred++;
            if (m_hit(update_pc_i)) begin
                if (update_taken_i) begin
                    m_cnt[ix]    = (m_cnt[ix] < 3) ? m_cnt[ix] + 1 : 3;
                    m_target[ix] = update_target_i;
                end else begin
                    m_cnt[ix] = (m_cnt[ix] > 0) ? m_cnt[ix] - 1 : 0;
                end
            end else if (update_taken_i) begin
                m_valid[ix]  = 1'b1;
                m_tag[ix]    = tag_of(update_pc_i);
                m_target[ix] = update_target_i;
                m_cnt[ix]    = 2;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_model(input string name);
        chk({name, "_hit"}, {31'd0, pred_hit_o}, {31'd0, m_hit(lookup_pc_i)});
        chk({name, "_taken"}, {31'd0, pred_taken_o}, {31'd0, m_taken(lookup_pc_i)});
        chk({name, "_next"}, pred_next_pc_o, m_next(lookup_pc_i));
`ifdef BRANCH_TARGET_PREDICTOR_STATS_EN
        chk({name, "_lookups"}, stat_lookups_o, m_lookups);
        chk({name, "_mispred"}, stat_mispredicts_o, m_mispred);
`endif
    endtask

    task automatic check_now(input string name, input logic h, input logic t, input logic [31:0] n);
        chk({name, "_hit"}, {31'd0, pred_hit_o}, {31'd0, h});
        chk({name, "_taken"}, {31'd0, pred_taken_o}, {31'd0, t});
        chk({name, "_next"}, pred_next_pc_o, n);
    endtask

    // Drive one cycle's inputs, let them settle, and check against the model.
    task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                         input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic inv, input string name);
        lookup_valid_i  = lv;
        lookup_pc_i     = lpc;
        update_valid_i  = uv;
        update_pc_i     = upc;
        update_taken_i  = ut;
        update_target_i = utgt;
        invalidate_i    = inv;
        #1;
        check_model(name);
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (!rst_i) model_clock();
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input string name);
        drive(1'b0, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, name);
    endtask

    task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        drive(1'b0, pc, 1'b1, pc, t, tgt, 1'b0, "train");
        tick();
    endtask

    initial begin
        logic [31:0] pc, upc, tg;
        model_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;

        // 1: reset state and wrap of the fall-through PC
        lookup(32'h0000_0100, "t1a");
        check_now("t1a", 1'b0, 1'b0, 32'h0000_0104);
        lookup(32'hFFFF_FFFC, "t1b");
        check_now("t1b", 1'b0, 1'b0, 32'h0000_0000);
        tick();

        // 2: allocation and saturating increment
        train(32'h100, 1'b1, 32'h200);
        lookup(32'h100, "t2a");
        check_now("t2a", 1'b1, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);

        // 3: saturating decrement from 3 down to 0 and hold
        train(32'h100, 1'b0, 32'h0);
        lookup(32'h100, "t3a");
        check_now("t3a", 1'b1, 1'b1, 32'h200);
        train(32'h100, 1'b0, 32'h0);
        lookup(32'h100, "t3b");
        check_now("t3b", 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b0, 32'h0);
        train(32'h100, 1'b0, 32'h0);
        lookup(32'h100, "t3c");
        check_now("t3c", 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b1, 32'h200);
        lookup(32'h100, "t3d");
        check_now("t3d", 1'b1, 1'b0, 32'h104);

        // 4: aliasing and no allocation on not-taken misses
        lookup(32'h140, "t4a");
        check_now("t4a", 1'b0, 1'b0, 32'h144);
        train(32'h140, 1'b1, 32'h300);
        lookup(32'h140, "t4b");
        check_now("t4b", 1'b1, 1'b1, 32'h300);
        lookup(32'h100, "t4c");
        check_now("t4c", 1'b0, 1'b0, 32'h104);
        train(32'h180, 1'b0, 32'h0);
        lookup(32'h180, "t4d");
        check_now("t4d", 1'b0, 1'b0, 32'h184);

        // 5: invalidate wins over update; lookup sees pre-update state
        drive(1'b0, 32'h140, 1'b1, 32'h100, 1'b1, 32'h400, 1'b1, "t5inv");
        tick();
        lookup(32'h100, "t5a");
        check_now("t5a", 1'b0, 1'b0, 32'h104);
        lookup(32'h140, "t5b");
        check_now("t5b", 1'b0, 1'b0, 32'h144);
        train(32'h100, 1'b1, 32'h500);
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h600, 1'b0, "t5c");
        check_now("t5c", 1'b1, 1'b1, 32'h500);
        tick();
        lookup(32'h100, "t5d");
        check_now("t5d", 1'b1, 1'b1, 32'h600);

        // randomized traffic over a small tag pool so entries hit and alias
        for (int n = 0; n < 600; n++) begin
            pc  = ($urandom_range(0, 3) == 3 ? 32'h03FF_FFFF : 32'($urandom_range(0, 2))) * 32'd64
                  + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            upc = ($urandom_range(0, 3) == 3 ? 32'h03FF_FFFF : 32'($urandom_range(0, 2))) * 32'd64
                  + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            tg  = $urandom_range(0, 3) == 0 ? 32'h1000 : $urandom;
            drive(1'($urandom), pc, 1'($urandom_range(0, 3) != 0), upc, 1'($urandom),
                  tg, $urandom_range(0, 40) == 0, "rnd");
            tick();
        end

        // 6: asynchronous reset between edges clears hits immediately
        train(32'h100, 1'b1, 32'h700);
        lookup(32'h100, "t6a");
        check_now("t6a", 1'b1, 1'b1, 32'h700);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        check_now("t6b", 1'b0, 1'b0, 32'h104);
        check_model("t6b");
        tick();
        rst_i = 1'b0;
        #1;

`ifdef BRANCH_TARGET_PREDICTOR_STATS_EN
        chk("st_zero_l", stat_lookups_o, 32'd0);
        chk("st_zero_m", stat_mispredicts_o, 32'd0);
        drive(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, "st1"); tick();
        drive(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, "st2"); tick();
        drive(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h240, 1'b0, "st3"); tick();
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "st4"); tick();
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "st5"); tick();
        drive(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "st6");
        chk("st_lookups", stat_lookups_o, 32'd5);
        chk("st_mispred", stat_mispredicts_o, 32'd2);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("st_rst_l", stat_lookups_o, 32'd0);
        chk("st_rst_m", stat_mispredicts_o, 32'd0);
        tick();
        rst_i = 1'b0;
        #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch target buffer (BTB) with per-entry saturating direction counters for the IF stage of the pipelined core.
- Gives the PC-select path a same-cycle next-PC prediction, so taken branches and jumps no longer cost a flush.
- Trained from the ID stage, where branch outcome and target are resolved.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, >= 2; IDX_W = log2(ENTRIES).
- PC_W, 32, PC and target width.
- CNT_W, 2, direction counter width; >= 1.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- lookup_valid_i  input  1  IF stage presents a fetch PC this cycle.
- lookup_pc_i  input  PC_W  fetch PC.
- pred_hit_o  output  1  valid entry with matching tag.
- pred_taken_o  output  1  predicted taken.
- pred_next_pc_o  output  PC_W  predicted next fetch PC.
- update_valid_i  input  1  resolved branch/jump from ID this cycle.
- update_pc_i  input  PC_W  PC of resolved instruction.
- update_taken_i  input  1  actual outcome.
- update_target_i  input  PC_W  actual target.
- invalidate_i  input  1  clear all entries.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2].
  - tag = pc[PC_W-1:IDX_W+2].
  - pc[1:0] ignored.
- Entry fields: valid, tag, target[PC_W], cnt[CNT_W].
- Lookup is combinational from lookup_pc_i and the current table (zero latency):
  - pred_hit_o = valid && tag match.
  - pred_taken_o = pred_hit_o && cnt MSB.
  - pred_next_pc_o = pred_taken_o ? target : lookup_pc_i + 4 (mod 2^PC_W; wraps at top of address space).
- lookup_valid_i does not gate lookup outputs; it feeds statistics only.
- Update is registered on the rising clk_i edge when update_valid_i = 1, using the update index:
  - Hit, taken: cnt saturating increment (max all-ones); target <= update_target_i.
  - Hit, not taken: cnt saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate (overwrite any aliasing entry). valid <= 1, tag, target <= update_target_i, cnt <= weakly taken (MSB 1, rest 0; 2'b10 for CNT_W=2).
  - Miss, not taken: no change.
- Reset, while rst_i high, immediately, regardless of clock:
  - All valid cleared.
  - All cnt set to weakly not taken (MSB 0, rest 1; 2'b01).
  - All tags and targets set to 0.
  - Outputs therefore read hit 0, taken 0, next = lookup_pc_i + 4.
- Reset mid-update: the update is lost; there is no partial write.
- invalidate_i (synchronous, single cycle): clear all valid bits; cnt, tag and target unchanged.
- Simultaneous events:
  - invalidate_i and update_valid_i in the same cycle: invalidate wins, the update is discarded.
  - Lookup and update to the same index in the same cycle: lookup returns pre-update contents (no bypass); the new state is visible the next cycle.
- Single write port. At most one update per cycle.

Optional Feature:
- Macro: BRANCH_TARGET_PREDICTOR_STATS_EN.
- Defined: adds two output ports, both 32-bit wrapping counters, reset to 0 and cleared by rst_i only (not by invalidate_i):
  - stat_lookups_o: +1 each cycle lookup_valid_i = 1.
  - stat_mispredicts_o: +1 on each accepted update (not discarded by invalidate_i) where the pre-update prediction for update_pc_i was wrong.
    - Wrong direction: predicted-taken != update_taken_i.
    - Wrong target: predicted taken, actual taken, and stored target != update_target_i.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
All scenarios use ENTRIES=16, PC_W=32, CNT_W=2.
1. Reset, then lookup_pc_i=0x100 -> hit 0, taken 0, next 0x104; lookup_pc_i=0xFFFFFFFC -> next 0x00000000.
2. Update pc=0x100, taken=1, target=0x200; next cycle lookup 0x100 -> hit 1, taken 1, next 0x200 (cnt=2). Second taken update -> cnt 3; third -> stays 3.
3. From cnt=3 on 0x100, three not-taken updates -> cnt 2 (taken 1), cnt 1 (taken 0, next 0x104, hit 1), cnt 0. Fourth not-taken -> stays 0.
4. Alias test, 0x100 and 0x140 share index 0 with different tags:
   - With 0x100 allocated, lookup 0x140 -> hit 0.
   - Taken update 0x140 -> target 0x300; then lookup 0x140 -> next 0x300, and lookup 0x100 -> hit 0.
   - Not-taken update on a missing PC (0x180) -> no allocation; lookup 0x180 -> hit 0.
5. Same-cycle events:
   - invalidate_i=1 with taken update 0x100 in the same cycle -> every lookup afterwards misses.
   - Same-cycle lookup and update of 0x100 -> old value that cycle, new value next cycle.
6. rst_i asserted asynchronously between clock edges with entries populated -> hit 0 immediately, before the next edge.
   - With STATS_EN: 5 lookup cycles and 2 wrong predictions give stat_lookups_o=5, stat_mispredicts_o=2; both read 0 after rst_i.
